// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction/address widths, the NOP encoding and
// the branch offset field positions used by the fetch stage.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  localparam int BR26_MSB = 25;
  localparam int BR26_LSB = 0;
  localparam int CB19_MSB = 23;
  localparam int CB19_LSB = 5;

  localparam int BR26_W = BR26_MSB - BR26_LSB + 1;
  localparam int CB19_W = CB19_MSB - CB19_LSB + 1;

endpackage

// File: rtl/branch_target.sv
// PC-relative branch target: sign-extend the selected word offset, scale by 4
// and add to the branch's own PC (modulo 2^64).
module branch_target
  import cpu_pkg::*;
(
  input  logic [BR26_MSB:0]  field,
  input  logic               uncond,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  tgt
);

  logic [ADDR_W-1:0] off26;
  logic [ADDR_W-1:0] off19;
  logic [ADDR_W-1:0] off;

  assign off26 = {{(ADDR_W-BR26_W){field[BR26_MSB]}}, field[BR26_MSB:BR26_LSB]};
  assign off19 = {{(ADDR_W-CB19_W){field[CB19_MSB]}}, field[CB19_MSB:CB19_LSB]};
  assign off   = uncond ? off26 : off19;
  assign tgt   = pc + {off[ADDR_W-3:0], 2'b00};

endmodule

// File: rtl/en_reg.sv
// Enabled register with synchronous active-high reset to a parameterised value.
// Reset wins over a deasserted enable so a stalled pipeline can still be reset.
module en_reg #(
  parameter int              W       = 64,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register: next-PC selection (sequential,
// PC-relative, register), hazard stall and optional branch delay slot.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter bit                DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               BrTaken,
  input  logic               UncondBr,
  input  logic               pc_rd,
  input  logic [ADDR_W-1:0]  br_reg_val,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  link_pc
);

  localparam int IFID_W = INSTR_W + ADDR_W + 1;
  localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {ADDR_W{1'b0}}, 1'b0};

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  br_tgt;
  logic               take_reg;
  logic               take_rel;
  logic               redirect;
  logic               squash;
  logic [IFID_W-1:0]  ifid_d;
  logic [IFID_W-1:0]  ifid_q;

  branch_target u_branch_target (
    .field  (if_id_instr[BR26_MSB:0]),
    .uncond (UncondBr),
    .pc     (if_id_pc),
    .tgt    (br_tgt)
  );

  // Branch flags only mean something when a real instruction sits in ID.
  assign take_reg = if_id_valid & pc_rd;
  assign take_rel = if_id_valid & BrTaken;
  assign redirect = ~stall & (take_reg | take_rel);
  assign squash   = redirect & ~DELAY_SLOT;

  always_comb begin
    pc_d = pc_q + 64'd4;
    if (take_reg)      pc_d = br_reg_val;
    else if (take_rel) pc_d = br_tgt;
  end

  always_comb begin
    ifid_d = {imem_data, pc_q, 1'b1};
    if (squash) ifid_d = {NOP_INSTR, pc_q, 1'b0};
  end

  en_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .d     (pc_d),
    .q     (pc_q)
  );

  en_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_q[IFID_W-1 -: INSTR_W];
  assign if_id_pc    = ifid_q[ADDR_W:1];
  assign if_id_valid = ifid_q[0];
  assign link_pc     = if_id_pc + 64'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: delay-slot, squashing and wrapping-reset
// instances share the control inputs; each has its own instruction memory port.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        BrTaken;
  logic        UncondBr;
  logic        pc_rd;
  logic [63:0] br_reg_val;

  logic [63:0] a1, a0, aw;
  logic [31:0] d1, d0, dw;
  logic [31:0] i1, i0, iw;
  logic [63:0] p1, p0, pw;
  logic        v1, v0, vw;
  logic [63:0] l1, l0, lw;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] addr);
    case (addr)
      64'h40:  imem = 32'h14000010;          // B +16 words
      64'h100: imem = 32'hB4FFFF80;          // CBZ, imm19 = -4
      default: imem = {16'h9100, addr[15:0]};
    endcase
  endfunction

  assign d1 = imem(a1);
  assign d0 = imem(a0);
  assign dw = imem(aw);

  fetch_stage #(.RESET_PC(64'h0), .DELAY_SLOT(1'b1)) dut (
    .clk(clk), .reset(reset), .imem_addr(a1), .imem_data(d1), .stall(stall),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .br_reg_val(br_reg_val),
    .if_id_instr(i1), .if_id_pc(p1), .if_id_valid(v1), .link_pc(l1));

  fetch_stage #(.RESET_PC(64'h0), .DELAY_SLOT(1'b0)) dut_sq (
    .clk(clk), .reset(reset), .imem_addr(a0), .imem_data(d0), .stall(stall),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .br_reg_val(br_reg_val),
    .if_id_instr(i0), .if_id_pc(p0), .if_id_valid(v0), .link_pc(l0));

  fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DELAY_SLOT(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(aw), .imem_data(dw), .stall(stall),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .pc_rd(pc_rd), .br_reg_val(br_reg_val),
    .if_id_instr(iw), .if_id_pc(pw), .if_id_valid(vw), .link_pc(lw));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_br();
    BrTaken = 1'b0; UncondBr = 1'b0; pc_rd = 1'b0; br_reg_val = '0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    clr_br();

    // 1: reset and sequential fetch, wrap instance starts at -4
    step(2);
    chk("rst_addr",  a1, 64'h0);
    chk("rst_valid", v1, 1'b0);
    chk("rst_instr", i1, NOP);
    chk("rst_pc",    p1, 64'h0);
    chk("rst_wrap_addr", aw, 64'hFFFF_FFFF_FFFF_FFFC);
    reset = 1'b0;
    step();
    chk("seq1_addr",  a1, 64'h4);
    chk("seq1_valid", v1, 1'b1);
    chk("seq1_pc",    p1, 64'h0);
    chk("seq1_instr", i1, 32'h91000000);
    chk("wrap_addr",  aw, 64'h0);
    chk("wrap_pc",    pw, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("seq2_addr",  a1, 64'h8);
    chk("seq2_pc",    p1, 64'h4);

    // 2: B +16 at 0x40
    step(15);
    chk("b_id_pc",    p1, 64'h40);
    chk("b_id_instr", i1, 32'h14000010);
    BrTaken = 1'b1; UncondBr = 1'b1;
    #1;
    chk("b_link", l1, 64'h44);
    step();
    clr_br();
    chk("b_tgt_addr",  a1, 64'h80);
    chk("b_ds_pc",     p1, 64'h44);
    chk("b_ds_valid",  v1, 1'b1);
    chk("b_ds_instr",  i1, 32'h91000044);
    chk("b_sq_addr",   a0, 64'h80);
    chk("b_sq_valid",  v0, 1'b0);
    chk("b_sq_instr",  i0, NOP);
    chk("b_sq_pc",     p0, 64'h44);
    step();
    chk("b_tgt_id_pc", p1, 64'h80);
    chk("b_tgt_next",  a1, 64'h84);
    chk("b_sq_tgt_id", p0, 64'h80);
    chk("b_sq_valid2", v0, 1'b1);

    // flags ignored while ID holds a bubble
    reset = 1'b1;
    step();
    reset = 1'b0;
    BrTaken = 1'b1; UncondBr = 1'b1; pc_rd = 1'b1; br_reg_val = 64'h500;
    step();
    clr_br();
    chk("bubble_ignore", a1, 64'h4);

    // 4: BR with BrTaken also asserted, pc_rd wins
    pc_rd = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1; br_reg_val = 64'h2000;
    #1;
    chk("br_link", l1, 64'h4);
    step();
    clr_br();
    chk("br_addr", a1, 64'h2000);
    step();
    chk("br_id_pc", p1, 64'h2000);

    // 3: CBZ back from 0x100
    pc_rd = 1'b1; br_reg_val = 64'h100;
    step();
    clr_br();
    step();
    chk("cbz_id_pc",    p1, 64'h100);
    chk("cbz_id_instr", i1, 32'hB4FFFF80);
    BrTaken = 1'b1; UncondBr = 1'b0;
    step();
    clr_br();
    chk("cbz_taken", a1, 64'hF0);
    step(5);
    chk("cbz_again_pc", p1, 64'h100);
    step();
    chk("cbz_not_taken", a1, 64'h108);

    // 5: stall with a taken B in ID
    pc_rd = 1'b1; br_reg_val = 64'h40;
    step();
    clr_br();
    step();
    chk("st_id_pc", p1, 64'h40);
    BrTaken = 1'b1; UncondBr = 1'b1; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("st_addr",  a1, 64'h44);
      chk("st_pc",    p1, 64'h40);
      chk("st_instr", i1, 32'h14000010);
    end
    stall = 1'b0;
    step();
    clr_br();
    chk("st_release_addr", a1, 64'h80);
    chk("st_release_pc",   p1, 64'h44);

    // 6: reset arriving mid-stall with a pending branch
    stall = 1'b1;
    step();
    reset = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1;
    step();
    chk("rs_addr",  a1, 64'h0);
    chk("rs_valid", v1, 1'b0);
    chk("rs_instr", i1, NOP);
    chk("rs_wrap",  aw, 64'hFFFF_FFFF_FFFF_FFFC);
    reset = 1'b0; stall = 1'b0;
    step();
    clr_br();
    chk("rs_after_addr", a1, 64'h4);
    chk("rs_after_wrap", aw, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
